paddle_quadrature: RTL and testbench
====================================

# paddle_quadrature

Upstream input stage for the pong core: converts one player's two-phase rotary encoder (A/B pins) into a debounced, saturating paddle position for the `player1_*` / `player2_*` paddle path. One instance per player sits between the board pins and the pong core. It synchronises, debounces and quadrature-decodes the pins, then accumulates detents into a position register the game logic reads directly.

## Interface
- `WIDTH`, 5: paddle position width in bits.
- `MAX_POS`, 27: highest legal position, which must be less than 2^WIDTH.
- `DEBOUNCE`, 4: consecutive stable cycles required before a pin change is accepted; must be at least 1.
- `clk` in 1: system clock, the 12 MHz domain.
- `reset` in 1: asynchronous, active-high reset.
- `enc_a` in 1: raw encoder phase A, asynchronous to `clk`.
- `enc_b` in 1: raw encoder phase B, asynchronous to `clk`.
- `center` in 1: synchronous one-cycle request to recentre the paddle.
- `position` out WIDTH: current paddle position, 0..MAX_POS.
- `step_up` out 1: one-cycle pulse, one forward detent decoded.
- `step_down` out 1: one-cycle pulse, one reverse detent decoded.
- `error` out 1: one-cycle pulse, illegal quadrature transition detected.

## Operation
- **Synchroniser:** two flip-flops per pin; both reset to 0.
- **Debounce (per pin):**
  - Counter counts cycles where the synchronised value differs from the debounced value.
  - Counter clears whenever the two are equal.
  - When the count reaches DEBOUNCE, the debounced value takes the synchronised value and the counter clears.
  - Debounced value resets to 0.
- **Quadrature decode:** compares registered previous {a,b} with current debounced {a,b}.
  - Forward sequence 00→01→11→10→00: +1.
  - Reverse sequence: −1.
  - No change: 0.
  - Both bits changed in the same cycle: `error` pulse, phase accumulator cleared.
- **Phase accumulator:** signed 3-bit, reset 0.
  - Reaching +4: `step_up` pulse, accumulator cleared.
  - Reaching −4: `step_down` pulse, accumulator cleared.
- **Position:**
  - Reset value is MAX_POS/2 (integer division; 13 with defaults).
  - `step_up` increments, saturating at MAX_POS.
  - `step_down` decrements, saturating at 0.
  - Step pulses still fire when the position is saturated.
- **Center:** `center` sets position to MAX_POS/2 and clears the accumulator. It has priority over a step decoded in the same cycle; that step is discarded and its pulse is suppressed.
- **Exclusivity:** `step_up`, `step_down` and `error` are mutually exclusive.
- **Outputs:** all registered. Reset values: `position` = MAX_POS/2; `step_up`, `step_down`, `error` = 0.

## Timing
- **Latency:** a pin change held stable before clock edge 1 reaches the debounced register at edge 2+DEBOUNCE. The resulting pulse and `position` update occur at edge 3+DEBOUNCE, which is edge 7 with defaults.
- **Pulse alignment:** the `position` update and the corresponding step pulse occur on the same edge.
- **Glitch rejection:** a pin glitch lasting fewer than DEBOUNCE synchronised cycles has no effect.
- **Decode rate:** at most one decoded transition per cycle. Maximum usable rate is one pin edge per DEBOUNCE+1 cycles.
- **Reset mid-operation:**
  - All state returns to reset values immediately and asynchronously, including any partial accumulator.
  - After reset the previous-state register is 00. If the pins sit at 11, the first decode after reset produces `error`.
- **`center` timing:** takes effect on the next edge; `position` reads MAX_POS/2 one cycle after `center` is sampled high.

## Structure
- **Shared package `pong_pkg`:** quadrature phase constants (00, 01, 11, 10) and the transition-direction encoding (+1, −1, 0, illegal).
- **Sub-module `input_debounce`:** synchroniser plus stable-counter, parameterised by DEBOUNCE. Instantiated once per pin, so twice per encoder.
- **Top of this block:** the decoder, accumulator and position register stay here.

## Test plan
- **Reset:** assert `reset` with pins toggling → `position`=13, all pulses 0, throughout and after release.
- **One forward detent:** drive the forward sequence 00→01→11→10→00, each phase held 10 cycles → exactly one `step_up`, `position` 13→14. The pulse lands 7 edges after the final pin change.
- **Saturation:** 20 forward detents → `position` stops at 27 with 20 `step_up` pulses. Then 30 reverse detents → `position` stops at 0 with 30 `step_down` pulses.
- **Bounce rejection:** 2-cycle glitches on `enc_a` → no pulses, no position change. Next, a bouncy edge that settles → exactly one accepted transition.
- **Illegal transition:** force `enc_a` and `enc_b` to change together from 00 to 11 → one `error` pulse, accumulator cleared. A following partial detent of three forward transitions yields no `step_up`.
- **Center vs step:** assert `center` on the cycle a `step_up` would occur → `position`=13, no `step_up`, accumulator 0. Also assert `reset` mid-detent → a subsequent full detent yields exactly one step.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong definitions: quadrature phase codes and the decoded transition direction.
package pong_pkg;

    localparam logic [1:0] PHASE_0 = 2'b00;
    localparam logic [1:0] PHASE_1 = 2'b01;
    localparam logic [1:0] PHASE_2 = 2'b11;
    localparam logic [1:0] PHASE_3 = 2'b10;

    typedef enum logic [1:0] {
        DIR_NONE    = 2'd0,
        DIR_FWD     = 2'd1,
        DIR_REV     = 2'd2,
        DIR_ILLEGAL = 2'd3
    } dir_t;

    // Forward successor of a phase in the Gray sequence 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] phase_next(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PHASE_0: nxt = PHASE_1;
            PHASE_1: nxt = PHASE_2;
            PHASE_2: nxt = PHASE_3;
            default: nxt = PHASE_0;
        endcase
        return nxt;
    endfunction

    // Classify one step from prev to cur; a two-bit change cannot be resolved.
    function automatic dir_t quad_dir(input logic [1:0] prev, input logic [1:0] cur);
        dir_t d;
        if (prev == cur)
            d = DIR_NONE;
        else if ((prev ^ cur) == 2'b11)
            d = DIR_ILLEGAL;
        else if (phase_next(prev) == cur)
            d = DIR_FWD;
        else
            d = DIR_REV;
        return d;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw pin.
module input_debounce #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level
);

    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // The change is accepted on the DEBOUNCE-th consecutive cycle of disagreement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            sync_q1 <= pin;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/paddle_quadrature.sv
// Rotary encoder to paddle position: debounce, quadrature decode, detent accumulate, saturate.
module paddle_quadrature
    import pong_pkg::*;
#(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned MAX_POS  = 27,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             center,
    output logic [WIDTH-1:0] position,
    output logic             step_up,
    output logic             step_down,
    output logic             error
);

    localparam logic [WIDTH-1:0] POS_MAX = WIDTH'(MAX_POS);
    localparam logic [WIDTH-1:0] POS_MID = WIDTH'(MAX_POS / 2);

    logic              deb_a;
    logic              deb_b;
    logic [1:0]        prev_ab;
    logic [1:0]        cur_ab;
    logic signed [2:0] acc;
    logic signed [3:0] acc_sum;
    dir_t              dir;

    input_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .pin   (enc_a),
        .level (deb_a)
    );

    input_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .pin   (enc_b),
        .level (deb_b)
    );

    assign cur_ab = {deb_a, deb_b};
    assign dir    = quad_dir(prev_ab, cur_ab);

    // One extra bit so a full detent (+/-4) is visible before it wraps.
    always_comb begin
        acc_sum = {acc[2], acc};
        case (dir)
            DIR_FWD: acc_sum = acc_sum + 4'sd1;
            DIR_REV: acc_sum = acc_sum - 4'sd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_ab   <= PHASE_0;
            acc       <= '0;
            position  <= POS_MID;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            error     <= 1'b0;
        end else begin
            prev_ab   <= cur_ab;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            error     <= 1'b0;
            if (center) begin
                position <= POS_MID;
                acc      <= '0;
            end else if (dir == DIR_ILLEGAL) begin
                error <= 1'b1;
                acc   <= '0;
            end else if (acc_sum == 4'sd4) begin
                step_up <= 1'b1;
                acc     <= '0;
                if (position != POS_MAX)
                    position <= position + WIDTH'(1);
            end else if (acc_sum == -4'sd4) begin
                step_down <= 1'b1;
                acc       <= '0;
                if (position != '0)
                    position <= position - WIDTH'(1);
            end else begin
                acc <= acc_sum[2:0];
            end
        end
    end

endmodule

// File: tb/tb_paddle_quadrature.sv
// Directed bench for paddle_quadrature: vector table for detents/saturation plus corner sequences.
module tb_paddle_quadrature;

    logic       clk = 1'b0;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic       center;
    logic [4:0] position;
    logic       step_up;
    logic       step_down;
    logic       error;

    int vectors = 0;
    int fails   = 0;
    int up_cnt  = 0;
    int dn_cnt  = 0;
    int err_cnt = 0;
    int excl    = 0;

    typedef struct {
        logic [1:0] ab;
        logic       ctr;
        int         hold;
        int         exp_pos;
        int         exp_up;
        int         exp_dn;
        int         exp_err;
    } vec_t;

    vec_t vq[$];

    paddle_quadrature #(.WIDTH(5), .MAX_POS(27), .DEBOUNCE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .center    (center),
        .position  (position),
        .step_up   (step_up),
        .step_down (step_down),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Advance n edges, sampling 1 time unit after each edge and tallying pulses.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            up_cnt  += int'(step_up);
            dn_cnt  += int'(step_down);
            err_cnt += int'(error);
            if (int'(step_up) + int'(step_down) + int'(error) > 1)
                excl++;
        end
    endtask

    task automatic drive(input logic [1:0] ab);
        enc_a = ab[1];
        enc_b = ab[0];
    endtask

    task automatic phase(input logic [1:0] ab);
        drive(ab);
        step(10);
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] fwd [4];
        logic [1:0] rev [4];
        int e_pos;
        int e_up;
        int e_dn;

        fwd[0] = 2'b01; fwd[1] = 2'b11; fwd[2] = 2'b10; fwd[3] = 2'b00;
        rev[0] = 2'b10; rev[1] = 2'b11; rev[2] = 2'b01; rev[3] = 2'b00;

        // Table: 19 more forward detents (starting at 14), 30 reverse, then a centre request.
        e_pos = 14; e_up = 1; e_dn = 0;
        for (int k = 0; k < 19; k++)
            for (int p = 0; p < 4; p++) begin
                if (p == 3) begin
                    e_up++;
                    if (e_pos < 27) e_pos++;
                end
                vq.push_back('{fwd[p], 1'b0, 10, e_pos, e_up, e_dn, 0});
            end
        for (int k = 0; k < 30; k++)
            for (int p = 0; p < 4; p++) begin
                if (p == 3) begin
                    e_dn++;
                    if (e_pos > 0) e_pos--;
                end
                vq.push_back('{rev[p], 1'b0, 10, e_pos, e_up, e_dn, 0});
            end
        vq.push_back('{2'b00, 1'b1, 10, 13, 20, 30, 0});

        // Reset asserted with pins toggling.
        reset = 1'b1; center = 1'b0; drive(2'b00);
        #1;
        check("reset_pos_async", int'(position), 13);
        for (int i = 0; i < 10; i++) begin
            drive(2'(i));
            step(1);
        end
        check("reset_pos_held", int'(position), 13);
        check("reset_pulses", up_cnt + dn_cnt + err_cnt, 0);
        drive(2'b00);
        step(2);
        reset = 1'b0;
        step(10);
        check("post_reset_pos", int'(position), 13);
        check("post_reset_pulses", up_cnt + dn_cnt + err_cnt, 0);

        // One forward detent with exact pulse latency.
        phase(2'b01); phase(2'b11); phase(2'b10);
        check("detent_partial", up_cnt, 0);
        drive(2'b00);
        step(6);
        check("latency_edge6_step_up", int'(step_up), 0);
        step(1);
        check("latency_edge7_step_up", int'(step_up), 1);
        check("latency_edge7_pos", int'(position), 14);
        step(10);
        check("detent_one_pulse", up_cnt, 1);

        // Table-driven saturation sweep.
        foreach (vq[i]) begin
            drive(vq[i].ab);
            center = vq[i].ctr;
            step(1);
            center = 1'b0;
            step(vq[i].hold - 1);
            vectors++;
            if (int'(position) != vq[i].exp_pos || up_cnt != vq[i].exp_up ||
                dn_cnt != vq[i].exp_dn || err_cnt != vq[i].exp_err) begin
                fails++;
                $display("FAIL vec[%0d]: pos/up/dn/err got %0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
                         i, position, up_cnt, dn_cnt, err_cnt,
                         vq[i].exp_pos, vq[i].exp_up, vq[i].exp_dn, vq[i].exp_err);
            end
        end

        // Bounce: sit at 10 with three forward steps banked; glitches to 00 must not complete the detent.
        phase(2'b01); phase(2'b11); phase(2'b10);
        drive(2'b00); step(2); drive(2'b10); step(10);
        drive(2'b00); step(3); drive(2'b10); step(10);
        check("glitch_no_step", up_cnt, 20);
        check("glitch_pos", int'(position), 13);
        drive(2'b00); step(2); drive(2'b10); step(1);
        drive(2'b00); step(3); drive(2'b10); step(2);
        drive(2'b00); step(12);
        check("bouncy_edge_one_step", up_cnt, 21);
        check("bouncy_edge_pos", int'(position), 14);

        // Illegal transitions clear the accumulator.
        phase(2'b11);
        check("illegal_00_11_error", err_cnt, 1);
        phase(2'b10); phase(2'b00); phase(2'b01);
        check("partial_after_error", up_cnt, 21);
        phase(2'b10);
        check("illegal_01_10_error", err_cnt, 2);
        phase(2'b00); phase(2'b01); phase(2'b11);
        check("acc_cleared_by_error", up_cnt, 21);
        phase(2'b10);
        check("detent_after_error", up_cnt, 22);
        check("detent_after_error_pos", int'(position), 15);

        // Centre on the exact edge the step would land.
        phase(2'b00); phase(2'b01); phase(2'b11);
        drive(2'b10);
        step(6);
        center = 1'b1;
        step(1);
        center = 1'b0;
        check("center_pos", int'(position), 13);
        check("center_suppress_pulse", int'(step_up), 0);
        step(10);
        check("center_no_late_step", up_cnt, 22);
        phase(2'b00); phase(2'b01); phase(2'b11);
        check("center_acc_cleared", up_cnt, 22);
        phase(2'b10);
        check("detent_after_center", up_cnt, 23);
        check("detent_after_center_pos", int'(position), 14);

        // Reset mid-detent.
        phase(2'b00); phase(2'b01);
        reset = 1'b1;
        #1;
        check("reset_mid_pos_async", int'(position), 13);
        drive(2'b00);
        step(3);
        reset = 1'b0;
        step(10);
        phase(2'b01); phase(2'b11);
        check("reset_cleared_acc_a", up_cnt, 23);
        phase(2'b10);
        check("reset_cleared_acc_b", up_cnt, 23);
        phase(2'b00);
        check("detent_after_reset", up_cnt, 24);
        check("detent_after_reset_pos", int'(position), 14);

        // Pins at 11 across reset: first decode sees 00 -> 11.
        reset = 1'b1;
        drive(2'b11);
        step(3);
        reset = 1'b0;
        step(10);
        check("reset_at_11_error", err_cnt, 3);
        check("reset_at_11_pos", int'(position), 13);

        check("total_step_down", dn_cnt, 30);
        check("pulse_exclusivity", excl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
